// File: rtl/byte_serializer_pkg.sv
// Shared types and constants for the 32-bit to byte-stream serializer.
// Imported by the interface, the byte mux and the serializer top.
package byte_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int IDX_W          = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [7:0]        byte_t;

  localparam idx_t LAST_IDX = idx_t'(BYTES_PER_WORD - 1);

  // Lane 0 is bits [7:0]; lane 3 is bits [31:24].
  function automatic byte_t lane_byte(
    input word_t w,
    input idx_t  lane
  );
    byte_t b;
    b = '0;
    unique case (lane)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Word-in / byte-out handshake bundle for byte_serializer.
// slave is the serializer view; master is the environment view.
interface byte_serializer_if;
  import byte_serializer_pkg::*;

  logic  in_valid;
  word_t in_data;
  logic  in_ready;

  logic  out_valid;
  byte_t out_data;
  logic  out_last;
  logic  out_ready;

  logic  busy;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready,
    output busy
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/byte_serializer_byte_mux4.sv
// Combinational byte picker: word + stream index -> byte.
// LSB_FIRST selects whether index 0 maps to bits [7:0] or [31:24].
module byte_mux4
  import byte_serializer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  word_t word,
  input  idx_t  idx,
  output byte_t data
);

  idx_t lane;

  // MSB-first order walks lanes 3,2,1,0.
  assign lane = LSB_FIRST ? idx : ~idx;

  assign data = lane_byte(word, lane);

endmodule

// File: rtl/byte_serializer.sv
// Serializes 32-bit words into a byte stream, one byte per cycle.
// Reloads on the last-byte handshake so back-to-back words have no gap.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  byte_serializer_if.slave   bus
);

  state_t state;
  state_t state_nx;
  idx_t   idx;
  idx_t   idx_nx;
  word_t  hold;
  word_t  hold_nx;

  logic   in_ready;
  logic   out_valid;
  logic   last;
  byte_t  mux_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      hold  <= hold_nx;
    end
  end

  assign last = (state == SEND) && (idx == LAST_IDX);

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    hold_nx   = hold;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          hold_nx  = bus.in_data;
          idx_nx   = '0;
          state_nx = SEND;
        end
      end
      (state == SEND): begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (last) begin
            // Freeing the hold register lets a new word in now.
            in_ready = 1'b1;
            idx_nx   = '0;
            if (bus.in_valid) begin
              hold_nx = bus.in_data;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            idx_nx = idx + idx_t'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  byte_mux4 #(
    .LSB_FIRST (LSB_FIRST)
  ) u_mux (
    .word (hold),
    .idx  (idx),
    .data (mux_byte)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mux_byte : '0;
  assign bus.out_last  = last;
  assign bus.busy      = (state == SEND);

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer (MSB-first and LSB-first).
// Inputs change and outputs are checked 1ns after each falling edge.
module tb_byte_serializer;
  import byte_serializer_pkg::*;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  byte_serializer_if bus ();
  byte_serializer_if bus2 ();

  byte_serializer #(
    .LSB_FIRST (1'b0)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  byte_serializer #(
    .LSB_FIRST (1'b1)
  ) u_lsb (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.in_data = '0;
    bus2.out_ready = 1'b0;
    #1;
    n_cmp += 5;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid got %b want 0", bus.out_valid);
    end
    if (bus.out_last !== 1'b0) begin
      n_err++;
      $display("FAIL rst_last got %b want 0", bus.out_last);
    end
    if (bus.out_data !== 8'h00) begin
      n_err++;
      $display("FAIL rst_data got %h want 00", bus.out_data);
    end
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_busy got %b want 0", bus.busy);
    end
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    byte_t exp [4];
    exp = '{8'h80, 8'h40, 8'h20, 8'h10};
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h80402010;
    bus.out_ready = 1'b1;
    #1;
    n_cmp += 2;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_idle_rdy got %b want 1", bus.in_ready);
    end
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle_vld got %b want 0", bus.out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_cmp += 4;
      if (bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL single_vld[%0d] got %b want 1", i, bus.out_valid);
      end
      if (bus.out_data !== exp[i]) begin
        n_err++;
        $display("FAIL single_data[%0d] got %h want %h",
                 i, bus.out_data, exp[i]);
      end
      if (bus.out_last !== (i == 3)) begin
        n_err++;
        $display("FAIL single_last[%0d] got %b want %b",
                 i, bus.out_last, (i == 3));
      end
      if (bus.in_ready !== (i == 3)) begin
        n_err++;
        $display("FAIL single_rdy[%0d] got %b want %b",
                 i, bus.in_ready, (i == 3));
      end
    end
    @(negedge clk);
    #1;
    n_cmp += 2;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_end_busy got %b want 0", bus.busy);
    end
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_end_vld got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    byte_t exp [8];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44,
            8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h11223344;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.in_data = 32'hAABBCCDD;
      if (i == 4) bus.in_valid = 1'b0;
      #1;
      n_cmp += 4;
      if (bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_vld[%0d] got %b want 1", i, bus.out_valid);
      end
      if (bus.out_data !== exp[i]) begin
        n_err++;
        $display("FAIL b2b_data[%0d] got %h want %h",
                 i, bus.out_data, exp[i]);
      end
      if (bus.in_ready !== (i == 3 || i == 7)) begin
        n_err++;
        $display("FAIL b2b_rdy[%0d] got %b want %b",
                 i, bus.in_ready, (i == 3 || i == 7));
      end
      if (bus.out_last !== (i == 3 || i == 7)) begin
        n_err++;
        $display("FAIL b2b_last[%0d] got %b want %b",
                 i, bus.out_last, (i == 3 || i == 7));
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_backpressure();
    word_t junk [3];
    byte_t exp [3];
    junk = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C};
    exp = '{8'hAD, 8'hBE, 8'hEF};
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDEADBEEF;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_data !== 8'hDE) begin
      n_err++;
      $display("FAIL bp_first got %h want de", bus.out_data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = junk[k];
      #1;
      n_cmp += 3;
      if (bus.out_data !== 8'hAD) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got %h want ad", k, bus.out_data);
      end
      if (bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_rdy[%0d] got %b want 0", k, bus.in_ready);
      end
      if (bus.out_last !== 1'b0) begin
        n_err++;
        $display("FAIL bp_last[%0d] got %b want 0", k, bus.out_last);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      n_cmp += 2;
      if (bus.out_data !== exp[i]) begin
        n_err++;
        $display("FAIL bp_resume[%0d] got %h want %h",
                 i, bus.out_data, exp[i]);
      end
      if (bus.out_last !== (i == 2)) begin
        n_err++;
        $display("FAIL bp_rlast[%0d] got %b want %b",
                 i, bus.out_last, (i == 2));
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_end_vld got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_lsb_first();
    byte_t exp [4];
    exp = '{8'h04, 8'h03, 8'h02, 8'h01};
    @(negedge clk);
    bus2.in_valid = 1'b1;
    bus2.in_data = 32'h01020304;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus2.in_valid = 1'b0;
      #1;
      n_cmp += 2;
      if (bus2.out_data !== exp[i]) begin
        n_err++;
        $display("FAIL lsb_data[%0d] got %h want %h",
                 i, bus2.out_data, exp[i]);
      end
      if (bus2.out_last !== (i == 3)) begin
        n_err++;
        $display("FAIL lsb_last[%0d] got %b want %b",
                 i, bus2.out_last, (i == 3));
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus2.busy !== 1'b0) begin
      n_err++;
      $display("FAIL lsb_end_busy got %b want 0", bus2.busy);
    end
  endtask

  task automatic test_reset_mid_word();
    byte_t exp [4];
    exp = '{8'h00, 8'h00, 8'h00, 8'h55};
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 32'hCAFEF00D;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.out_data !== 8'hF0) begin
      n_err++;
      $display("FAIL mid_pre got %h want f0", bus.out_data);
    end
    reset_n = 1'b0;
    #1;
    n_cmp += 5;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_vld got %b want 0", bus.out_valid);
    end
    if (bus.out_data !== 8'h00) begin
      n_err++;
      $display("FAIL mid_rst_data got %h want 00", bus.out_data);
    end
    if (bus.out_last !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_last got %b want 0", bus.out_last);
    end
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_busy got %b want 0", bus.busy);
    end
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_rst_rdy got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h00000055;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_cmp += 3;
      if (bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL post_vld[%0d] got %b want 1", i, bus.out_valid);
      end
      if (bus.out_data !== exp[i]) begin
        n_err++;
        $display("FAIL post_data[%0d] got %h want %h",
                 i, bus.out_data, exp[i]);
      end
      if (bus.out_last !== (i == 3)) begin
        n_err++;
        $display("FAIL post_last[%0d] got %b want %b",
                 i, bus.out_last, (i == 3));
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_end_busy got %b want 0", bus.busy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lsb_first();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter LSB_FIRST, default 0: 0 = emit bits[31:24] first, 1 = emit bits[7:0] first.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream word present on in_data.
REQ-005 in_data  input  32  word to serialize.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 out_valid  output  1  out_data holds a valid byte.
REQ-008 out_data  output  8  current byte.
REQ-009 out_last  output  1  current byte is the 4th byte of its word.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 busy  output  1  high while any byte of a word is pending.

Function
REQ-012 Transfer rule: input handshake = in_valid & in_ready; output handshake = out_valid & out_ready; both are evaluated on the same rising edge.
REQ-013 States: IDLE (no word held) and SEND (word held, byte index idx 0..3).
REQ-014 IDLE: in_ready=1, out_valid=0; an input handshake latches in_data into the hold register, sets idx=0, and moves to SEND.
REQ-015 SEND: out_valid=1; out_data = byte idx of the held word in the order set by LSB_FIRST (MSB-first: idx0=[31:24], idx1=[23:16], idx2=[15:8], idx3=[7:0]).
REQ-016 out_last = 1 exactly when state=SEND and idx=3.
REQ-017 An output handshake with idx<3 increments idx; with no handshake, idx, out_data and the hold register stay stable.
REQ-018 in_ready = (state==IDLE) | (state==SEND & idx==3 & out_ready); this is a combinational path from out_ready to in_ready.
REQ-019 Last byte consumed and input handshake in the same cycle: load the new word, set idx=0, remain in SEND; no bubble cycle.
REQ-020 Last byte consumed without an input handshake: return to IDLE.
REQ-021 Sustained throughput is 1 byte/cycle; latency from input handshake to first out_valid is 1 cycle.
REQ-022 in_data is ignored whenever in_ready=0; a word is never overwritten before its last byte handshakes.
REQ-023 busy = (state==SEND).
REQ-024 idx is 2 bits and never wraps silently: advancing from 3 occurs only via REQ-019 or REQ-020.

Reset
REQ-025 reset_n low asynchronously forces state=IDLE, idx=0, hold register=0, out_valid=0, out_last=0, out_data=8'h00, busy=0, in_ready=1 (combinational, from IDLE).
REQ-026 Reset in mid-word discards the remaining bytes; after release, no byte of the discarded word is emitted.
REQ-027 Reset release is seen at the first rising edge with reset_n high; the block accepts a word on that edge.

Structure
REQ-028 Shared package byte_serializer_pkg holds the state encodings (IDLE=1'b0, SEND=1'b1), the byte-index width (2), and the bytes-per-word constant (4).
REQ-029 A single sub-module byte_mux4 (32-bit word + 2-bit index + LSB_FIRST -> 8-bit byte, purely combinational) does byte selection; the FSM, index counter and hold register stay in byte_serializer.
REQ-030 All sequential logic sits in one always block sensitive to posedge clk and negedge reset_n.

Verification
REQ-031 in_data=32'h80402010, out_ready=1 constant -> out_data 80,40,20,10 on 4 consecutive cycles; out_last only with 10; then IDLE.
REQ-032 Back-to-back words 32'h11223344 and 32'hAABBCCDD, both valids high, out_ready=1 -> 8 consecutive bytes 11..44 then AA..DD, no gap; in_ready high only on the last-byte cycles.
REQ-033 Backpressure: out_ready low for 3 cycles at idx=1 of 32'hDEADBEEF -> out_data holds AD, in_ready=0, and in_data changes are ignored; stream then resumes BE, EF.
REQ-034 LSB_FIRST=1, in_data=32'h01020304 -> bytes 04,03,02,01 with out_last on 01.
REQ-035 Assert reset_n low after byte 2 of 32'hCAFEF00D -> outputs immediately take their reset values; after release, a new word 32'h00000055 emits 00,00,00,55 with no CAFEF00D bytes.
